// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} mult_state_t;
endpackage

// File: rtl/add_sub_n.sv
// Ripple adder/subtractor: s = a + b, or a - b when sub is set.
module add_sub_n #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] s
);
  assign s = a + (b ^ {WIDTH{sub}}) + {{(WIDTH-1){1'b0}}, sub};
endmodule

// File: rtl/seq_mult_n.sv
// Sequential WIDTH x WIDTH multiplier, one add-and-shift per cycle.
// Product is left in {Aval,Bval}; X carries the sign in signed mode.
module seq_mult_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic             Signed,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t      state, state_nxt;
  logic [WIDTH-1:0] a, b, m;
  logic             x, mode, busy, done;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   xa, m_ext, sum, t;
  logic             sub;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Run) state_nxt = ITER;
               else if (LoadB) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      ITER:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (!Run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Last step of a signed multiply subtracts: the multiplier MSB has negative weight.
  assign xa    = {x, a};
  assign m_ext = {mode & m[WIDTH-1], m};
  assign sub   = mode && (cnt == LAST);

  add_sub_n #(.WIDTH(WIDTH + 1)) u_add_sub (
    .a   (xa),
    .b   (m_ext),
    .sub (sub),
    .s   (sum)
  );

  assign t = b[0] ? sum : xa;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      m     <= '0;
      x     <= 1'b0;
      mode  <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == LOAD) || (state_nxt == ITER);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: if (Run) begin
          m    <= S;
          mode <= Signed;
          a    <= '0;
          x    <= 1'b0;
          cnt  <= '0;
        end
        LOAD: begin
          a <= '0;
          x <= 1'b0;
          b <= S;
        end
        ITER: begin
          x   <= mode & t[WIDTH];
          a   <= t[WIDTH:1];
          b   <= {t[0], b[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign Aval = a;
  assign Bval = b;
  assign X    = x;
  assign Busy = busy;
  assign Done = done;
endmodule

// File: tb/tb_seq_mult_n.sv
// Directed bench for seq_mult_n: transaction-level model plus literal product checks.
module tb_seq_mult_n;
  localparam int W = 8;

  logic         Clk = 1'b0, Reset = 1'b1, LoadB = 1'b0, Run = 1'b0, Signed = 1'b0;
  logic [W-1:0] S = '0;
  logic [W-1:0] Aval, Bval;
  logic         X, Busy, Done;

  logic         LoadB16 = 1'b0, Run16 = 1'b0;
  logic [15:0]  S16 = '0, Aval16, Bval16;
  logic         X16, Busy16, Done16;

  int n_chk = 0, n_pass = 0;
  bit cmp_en = 1'b0;

  always #5 Clk = ~Clk;

  seq_mult_n #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .Signed(Signed), .S(S),
    .Aval(Aval), .Bval(Bval), .X(X), .Busy(Busy), .Done(Done)
  );

  seq_mult_n #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB16), .Run(Run16), .Signed(Signed), .S(S16),
    .Aval(Aval16), .Bval(Bval16), .X(X16), .Busy(Busy16), .Done(Done16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: 0 idle, 1 load, 2 multiplying, 3 done. Product from plain arithmetic.
  int          m_st = 0, m_cnt = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_m = '0;
  logic        m_x = 1'b0, m_sg = 1'b0;
  logic [2*W-1:0] p;

  always @(posedge Clk) begin
    if (Reset) begin
      m_st = 0; m_a = '0; m_b = '0; m_m = '0; m_x = 1'b0; m_sg = 1'b0;
    end else begin
      case (m_st)
        0: if (Run) begin m_st = 2; m_cnt = 0; m_m = S; m_sg = Signed; end
           else if (LoadB) m_st = 1;
        1: begin m_a = '0; m_x = 1'b0; m_b = S; m_st = 0; end
        2: begin
          m_cnt++;
          if (m_cnt == W) begin
            if (m_sg) p = $signed(m_b) * $signed(m_m);
            else      p = (2*W)'(m_b) * (2*W)'(m_m);
            m_a = p[2*W-1:W];
            m_b = p[W-1:0];
            m_x = m_sg & p[2*W-1];
            m_st = 3;
          end
        end
        default: if (!Run) m_st = 0;
      endcase
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("busy", Busy, 64'(m_st == 1 || m_st == 2));
      chk("done", Done, 64'(m_st == 3));
      if (m_st != 2) begin
        chk("aval", Aval, m_a);
        chk("bval", Bval, m_b);
        chk("x", X, m_x);
      end
    end
  end

  task automatic load_b(input logic [W-1:0] v);
    LoadB = 1'b1; S = v;
    @(negedge Clk);
    LoadB = 1'b0;
    @(negedge Clk);
    chk("load_b", Bval, v);
  endtask

  task automatic mult(input string nm, input logic [W-1:0] v, input logic sg,
                      input logic [2*W-1:0] ep, input logic ex,
                      input logic lb_start, input logic lb_iter);
    int cyc;
    S = v; Signed = sg; Run = 1'b1; LoadB = lb_start;
    @(negedge Clk);
    // operands and mode must be ignored once multiplying
    S = ~v; Signed = ~sg; LoadB = lb_iter;
    cyc = 0;
    while (!Done && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'(W));
    chk({nm, " product"}, {Aval, Bval}, ep);
    chk({nm, " x"}, X, ex);
    repeat (2) @(negedge Clk);
    chk({nm, " hold"}, {Done, Aval, Bval}, {1'b1, ep});
    LoadB = 1'b0; Run = 1'b0;
    @(negedge Clk);
    chk({nm, " idle"}, Done, 0);
  endtask

  initial begin
    int cyc;
    Reset = 1'b1;
    @(negedge Clk);
    cmp_en = 1'b1;
    @(negedge Clk);
    chk("reset out", {Aval, Bval, X, Busy, Done}, 0);
    Reset = 1'b0;

    load_b(8'hFF); mult("s_m1xm1",   8'hFF, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    load_b(8'hFF); mult("u_ffxff",   8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b0, 1'b0);
    load_b(8'h7F); mult("s_7fx80",   8'h80, 1'b1, 16'hC080, 1'b1, 1'b0, 1'b0);
    load_b(8'hFB); mult("s_m5x3",    8'h03, 1'b1, 16'hFFF1, 1'b1, 1'b0, 1'b0);
    load_b(8'h80); mult("s_80x80",   8'h80, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
    load_b(8'h00); mult("s_0xa5",    8'hA5, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a multiply
    load_b(8'h55);
    S = 8'h33; Signed = 1'b0; Run = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b1; Run = 1'b0;
    @(negedge Clk);
    chk("reset mid iter", {Aval, Bval, X, Busy, Done}, 0);
    Reset = 1'b0;
    @(negedge Clk);

    load_b(8'h0D); mult("lb_iter",   8'h0B, 1'b0, 16'h008F, 1'b0, 1'b0, 1'b1);
    mult("run_lb",                    8'h02, 1'b0, 16'h011E, 1'b0, 1'b1, 1'b0);

    // 16-bit: most negative squared
    Signed = 1'b1; LoadB16 = 1'b1; S16 = 16'h8000;
    @(negedge Clk);
    LoadB16 = 1'b0;
    @(negedge Clk);
    Run16 = 1'b1;
    @(negedge Clk);
    cyc = 0;
    while (!Done16 && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    chk("w16 latency", 64'(cyc), 64'd16);
    chk("w16 product", {Aval16, Bval16}, 32'h4000_0000);
    chk("w16 x", X16, 0);
    Run16 = 1'b0;
    @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
